// File: rtl/inferred_shallow_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// It is written so that synthesis maps it to LUT RAM plus output flops.
module inferred_shallow_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 72
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; only the write strobe is gated by rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read is combinational from the array into one register. Because the
  // register samples the old array contents, a same-address collision is read-first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_inferred_shallow_ram.sv
// Directed bench for inferred_shallow_ram: a vector table of per-cycle inputs
// with expected rd_data after each edge, followed by a streaming wrap sequence.
module tb_inferred_shallow_ram;

  localparam int AW = 4;
  localparam int DW = 72;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  int total;
  int bad;

  typedef struct {
    logic          rst_n;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vq[$];

  inferred_shallow_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_addr (wr_addr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                              input logic chk, input logic [DW-1:0] exp);
    vec_t v;
    v.rst_n = r;
    v.we    = we;
    v.wa    = wa;
    v.wd    = wd;
    v.ra    = ra;
    v.chk   = chk;
    v.exp   = exp;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] rd_data=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // Inputs are driven on the falling edge. rd_data is sampled 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra);
    @(negedge clk);
    rst_n   = r;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] stream_word(input int i);
    logic [DW-1:0] w;
    w = {8'(i), 64'(i) * 64'h1111_0000_0001};
    return w;
  endfunction

  logic [DW-1:0] wide_a;
  logic [DW-1:0] wide_b;

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    wide_a  = {8'hF0, 64'h0000_0000_0000_0001};
    wide_b  = {8'h0F, 64'hFFFF_FFFF_FFFF_FFFE};

    // Initial reset: the output is held at 0.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4'd0, '0, 4'd5, 1'b1, '0);
    // Fill all addresses with addr*0x0101.
    for (int i = 0; i < 16; i++) add(1'b1, 1'b1, AW'(i), DW'(i * 'h0101), 4'd0, 1'b0, '0);
    // Read them back, one cycle per address.
    for (int i = 0; i < 16; i++) add(1'b1, 1'b0, 4'd0, '0, AW'(i), 1'b1, DW'(i * 'h0101));
    // Reset with rd_addr=5, then release.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4'd0, '0, 4'd5, 1'b1, '0);
    add(1'b1, 1'b0, 4'd0, '0, 4'd5, 1'b1, 72'h0505);
    // Read-first collision on address 3.
    add(1'b1, 1'b1, 4'd3, 72'hAA, 4'd3, 1'b1, 72'h0303);
    add(1'b1, 1'b1, 4'd3, 72'hBB, 4'd3, 1'b1, 72'hAA);
    add(1'b1, 1'b0, 4'd0, '0,     4'd3, 1'b1, 72'hBB);
    // Write-enable gating on address 7.
    add(1'b1, 1'b1, 4'd7, 72'h1234, 4'd0, 1'b1, 72'h0);
    add(1'b1, 1'b0, 4'd7, 72'hFFFF, 4'd0, 1'b1, 72'h0);
    add(1'b1, 1'b0, 4'd0, '0,       4'd7, 1'b1, 72'h1234);
    // A write during reset is suppressed, and the stored data is retained.
    add(1'b1, 1'b1, 4'd9, 72'h55, 4'd9, 1'b1, 72'h0909);
    add(1'b0, 1'b1, 4'd9, 72'h66, 4'd9, 1'b1, 72'h0);
    add(1'b1, 1'b0, 4'd0, '0,     4'd9, 1'b1, 72'h55);
    // A write and a read at different addresses in the same cycle.
    add(1'b1, 1'b1, 4'd2, 72'h777, 4'd4, 1'b1, 72'h0404);
    add(1'b1, 1'b0, 4'd0, '0,      4'd2, 1'b1, 72'h777);
    // The last write wins, using full-width data.
    add(1'b1, 1'b1, 4'd10, wide_a, 4'd10, 1'b1, 72'h0A0A);
    add(1'b1, 1'b1, 4'd10, wide_b, 4'd10, 1'b1, wide_a);
    add(1'b1, 1'b0, 4'd0,  '0,     4'd10, 1'b1, wide_b);

    foreach (vq[k]) begin
      cycle(vq[k].rst_n, vq[k].we, vq[k].wa, vq[k].wd, vq[k].ra);
      if (vq[k].chk) check("vec", k, rd_data, vq[k].exp);
    end

    // Streaming: write address i while reading i-1, wrapping past 15.
    // mem[0] still holds 0 from the fill, so the first read expects 0.
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b1, AW'(i), stream_word(i), AW'(i - 1));
      check("stream", i, rd_data, (i == 1) ? '0 : stream_word(i - 1));
    end
    cycle(1'b1, 1'b0, 4'd0, '0, AW'(20));
    check("stream_tail", 20, rd_data, stream_word(20));
    cycle(1'b1, 1'b0, 4'd0, '0, 4'd0);
    check("stream_wrap0", 16, rd_data, stream_word(16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
